// File: rtl/execute_unit.sv
// execute_unit: integer ALU, compare flags register {GT, E} and branch resolution.
module execute_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] brachtarget,
    input  logic             isunconditionalbranch,
    input  logic             isBeq,
    input  logic             isBgt,
    output logic [WIDTH-1:0] aluresult,
    output logic [WIDTH-1:0] branchpc,
    output logic             isbranchtaken,
    output logic [1:0]       flags
);
    logic [3:0] shamt;
    assign shamt = op2[3:0];
    always_comb begin
        aluresult = '0;
        case (aluop)
            4'd0:    aluresult = op1 + op2;
            4'd1,
            4'd2:    aluresult = op1 - op2;
            4'd3:    aluresult = op1 * op2;
            4'd4:    aluresult = op1 & op2;
            4'd5:    aluresult = op1 | op2;
            4'd6:    aluresult = ~op2;
            4'd7:    aluresult = op2;
            4'd8:    aluresult = op1 << shamt;
            4'd9:    aluresult = op1 >> shamt;
            4'd10:   aluresult = $signed(op1) >>> shamt;
            default: aluresult = '0;
        endcase
    end
    // Only cmp writes flags; a same-cycle branch still sees the pre-edge value.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) flags <= 2'b00;
        else if (aluop == 4'd2) flags <= {$signed(op1) > $signed(op2), op1 == op2};
    assign branchpc      = brachtarget;
    assign isbranchtaken = isunconditionalbranch | (isBeq & flags[0]) | (isBgt & flags[1]);
endmodule

// File: tb/tb_execute_unit.sv
// tb_execute_unit: directed scoreboard bench for execute_unit.
module tb_execute_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] op1 = '0, op2 = '0, brachtarget = '0;
    logic [3:0]  aluop = 4'd7;
    logic        isunconditionalbranch = 1'b0, isBeq = 1'b0, isBgt = 1'b0;
    logic [15:0] aluresult, branchpc;
    logic        isbranchtaken;
    logic [1:0]  flags;
    int          vectors = 0, miscompares = 0;

    typedef struct {
        string       tag;
        logic [15:0] res;
        logic [15:0] bpc;
        logic        tk;
        logic [1:0]  fl;
    } exp_t;
    exp_t sb[$];

    execute_unit #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .op1(op1), .op2(op2), .aluop(aluop),
        .brachtarget(brachtarget), .isunconditionalbranch(isunconditionalbranch),
        .isBeq(isBeq), .isBgt(isBgt), .aluresult(aluresult), .branchpc(branchpc),
        .isbranchtaken(isbranchtaken), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                         input logic u, input logic eq, input logic gt);
        op1 = a;
        op2 = b;
        aluop = op;
        isunconditionalbranch = u;
        isBeq = eq;
        isBgt = gt;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] res, input logic tk,
                              input logic [1:0] fl);
        exp_t e;
        sb.push_back('{tag, res, brachtarget, tk, fl});
        #1;
        e = sb.pop_front();
        vectors++;
        assert (aluresult === e.res) else begin
            miscompares++;
            $error("FAIL %s aluresult got %h want %h", e.tag, aluresult, e.res);
        end
        vectors++;
        assert (branchpc === e.bpc) else begin
            miscompares++;
            $error("FAIL %s branchpc got %h want %h", e.tag, branchpc, e.bpc);
        end
        vectors++;
        assert (isbranchtaken === e.tk) else begin
            miscompares++;
            $error("FAIL %s isbranchtaken got %b want %b", e.tag, isbranchtaken, e.tk);
        end
        vectors++;
        assert (flags === e.fl) else begin
            miscompares++;
            $error("FAIL %s flags got %b want %b", e.tag, flags, e.fl);
        end
    endtask

    task automatic edge_then_settle;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        brachtarget = 16'h1234;
        drive(16'h0000, 16'h0000, 4'd7, 1'b0, 1'b0, 1'b0);
        expect_out("rst_idle", 16'h0000, 1'b0, 2'b00);
        drive(16'h0000, 16'h0000, 4'd7, 1'b1, 1'b0, 1'b0);
        expect_out("rst_uncond", 16'h0000, 1'b1, 2'b00);
        drive(16'h0005, 16'h0005, 4'd2, 1'b0, 1'b0, 1'b0);
        edge_then_settle();
        expect_out("rst_holds_flags", 16'h0000, 1'b0, 2'b00);
        rst_n = 1'b1;

        drive(16'h0005, 16'h0005, 4'd2, 1'b0, 1'b0, 1'b0);
        expect_out("cmp_eq_pre", 16'h0000, 1'b0, 2'b00);
        edge_then_settle();
        drive(16'h0005, 16'h0005, 4'd7, 1'b0, 1'b1, 1'b0);
        expect_out("beq_taken", 16'h0005, 1'b1, 2'b01);
        drive(16'h0005, 16'h0005, 4'd7, 1'b0, 1'b0, 1'b1);
        expect_out("bgt_not_taken", 16'h0005, 1'b0, 2'b01);

        drive(16'h0007, 16'h0003, 4'd2, 1'b0, 1'b1, 1'b0);
        expect_out("cmp_gt_old_flags", 16'h0004, 1'b1, 2'b01);
        edge_then_settle();
        drive(16'h0007, 16'h0003, 4'd0, 1'b0, 1'b1, 1'b0);
        expect_out("beq_after_gt", 16'h000A, 1'b0, 2'b10);
        drive(16'h0007, 16'h0003, 4'd0, 1'b0, 1'b0, 1'b1);
        expect_out("bgt_taken", 16'h000A, 1'b1, 2'b10);
        drive(16'h0007, 16'h0003, 4'd0, 1'b0, 1'b1, 1'b1);
        expect_out("both_strobes", 16'h000A, 1'b1, 2'b10);

        drive(16'hFFFF, 16'h0001, 4'd2, 1'b0, 1'b0, 1'b0);
        expect_out("cmp_signed", 16'hFFFE, 1'b0, 2'b10);
        edge_then_settle();
        drive(16'hFFFF, 16'h0001, 4'd4, 1'b0, 1'b0, 1'b0);
        expect_out("signed_flags", 16'h0001, 1'b0, 2'b00);
        drive(16'hFFFF, 16'h0001, 4'd4, 1'b0, 1'b1, 1'b1);
        expect_out("signed_no_branch", 16'h0001, 1'b0, 2'b00);

        drive(16'h0007, 16'h0003, 4'd2, 1'b0, 1'b0, 1'b0);
        edge_then_settle();
        brachtarget = 16'hABCD;
        drive(16'h8000, 16'h0001, 4'd0, 1'b0, 1'b0, 1'b0);
        expect_out("add", 16'h8001, 1'b0, 2'b10);
        edge_then_settle();
        drive(16'h8000, 16'h0001, 4'd1, 1'b0, 1'b0, 1'b0);
        expect_out("sub", 16'h7FFF, 1'b0, 2'b10);
        edge_then_settle();
        drive(16'h8000, 16'h0001, 4'd10, 1'b0, 1'b0, 1'b0);
        expect_out("asr", 16'hC000, 1'b0, 2'b10);
        edge_then_settle();
        drive(16'h8000, 16'h0001, 4'd9, 1'b0, 1'b0, 1'b0);
        expect_out("lsr", 16'h4000, 1'b0, 2'b10);
        edge_then_settle();
        drive(16'h8000, 16'h0001, 4'd8, 1'b0, 1'b0, 1'b0);
        expect_out("lsl", 16'h0000, 1'b0, 2'b10);
        edge_then_settle();
        drive(16'h8000, 16'h0001, 4'd5, 1'b0, 1'b0, 1'b0);
        expect_out("or", 16'h8001, 1'b0, 2'b10);
        drive(16'h8000, 16'h0001, 4'd6, 1'b0, 1'b0, 1'b0);
        expect_out("not", 16'hFFFE, 1'b0, 2'b10);
        drive(16'h8000, 16'h0001, 4'd7, 1'b0, 1'b0, 1'b1);
        expect_out("mov", 16'h0001, 1'b1, 2'b10);
        drive(16'h00FF, 16'h0101, 4'd3, 1'b0, 1'b0, 1'b0);
        expect_out("mul", 16'hFFFF, 1'b0, 2'b10);
        drive(16'h1234, 16'h5678, 4'd3, 1'b0, 1'b0, 1'b0);
        expect_out("mul_wrap", 16'h0060, 1'b0, 2'b10);
        drive(16'h1234, 16'h0010, 4'd8, 1'b0, 1'b0, 1'b0);
        expect_out("lsl_zero_amt", 16'h1234, 1'b0, 2'b10);
        drive(16'h8000, 16'h000F, 4'd10, 1'b0, 1'b0, 1'b0);
        expect_out("asr_15", 16'hFFFF, 1'b0, 2'b10);
        drive(16'h1234, 16'h5678, 4'd11, 1'b0, 1'b0, 1'b0);
        expect_out("reserved_11", 16'h0000, 1'b0, 2'b10);
        drive(16'h1234, 16'h5678, 4'd15, 1'b0, 1'b0, 1'b0);
        edge_then_settle();
        expect_out("reserved_15", 16'h0000, 1'b0, 2'b10);

        drive(16'h0000, 16'h0000, 4'd7, 1'b0, 1'b0, 1'b1);
        expect_out("pre_async_rst", 16'h0000, 1'b1, 2'b10);
        rst_n = 1'b0;
        expect_out("async_rst", 16'h0000, 1'b0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
